// File: rtl/sm83_reg_bus_pch_seq_pkg.sv
// rtl/sm83_reg_bus_pch_seq_pkg.sv - shared types and helpers for the register bus sequencer
package sm83_reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCH  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } reg_bus_state_t;

    // Low bit index of bus b inside a packed BUSES*WIDTH vector
    function automatic int lane_lo(input int b, input int width);
        return b * width;
    endfunction

endpackage

// File: rtl/sm83_reg_bus_pch_seq_if.sv
// rtl/sm83_reg_bus_pch_seq_if.sv - handshake and bus signals of the precharge sequencer
interface sm83_reg_bus_pch_seq_if #(
    parameter int WIDTH = 8,
    parameter int BUSES = 3
);
    logic                     start;
    logic                     ready;
    logic [BUSES*WIDTH-1:0]   pd;
    logic [BUSES-1:0]         zero_en;
    logic [BUSES*WIDTH-1:0]   bus_q;
    logic [BUSES*WIDTH-1:0]   bus_q_n;
    logic [BUSES*WIDTH-1:0]   sample;
    logic                     sample_valid;
    logic                     stale;

    modport master (
        output start, pd, zero_en,
        input  ready, bus_q, bus_q_n, sample, sample_valid, stale
    );

    modport slave (
        input  start, pd, zero_en,
        output ready, bus_q, bus_q_n, sample, sample_valid, stale
    );
endinterface

// File: rtl/sm83_reg_bus_pch_seq_lane.sv
// rtl/sm83_reg_bus_pch_seq_lane.sv - one dynamic bus: precharge, discharge, zero-force and sample
module sm83_reg_bus_lane
    import sm83_reg_bus_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] ZERO_MASK = 8'h0F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pch_stb,
    input  logic             eval_stb,
    input  logic             dis_stb,
    input  logic             decay_stb,
    input  logic [WIDTH-1:0] pd,
    input  logic             zero_en,
    output logic [WIDTH-1:0] bus_q,
    output logic [WIDTH-1:0] sample
);

    logic [WIDTH-1:0] eval_val;

    assign eval_val = bus_q & ~pd & ~(zero_en ? ZERO_MASK : {WIDTH{1'b0}});

    // Decay wins over the idle discharge; both only ever clear bits
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q  <= '0;
            sample <= '0;
        end else if (pch_stb) begin
            bus_q <= '1;
        end else if (eval_stb) begin
            bus_q  <= eval_val;
            sample <= eval_val;
        end else if (decay_stb) begin
            bus_q <= '0;
        end else if (dis_stb) begin
            bus_q <= bus_q & ~pd;
        end
    end

    ap_no_rise: assert property (@(posedge clk) disable iff (reset)
        !pch_stb |=> ((bus_q & ~$past(bus_q)) == '0));

endmodule

// File: rtl/sm83_reg_bus_pch_seq.sv
// rtl/sm83_reg_bus_pch_seq.sv - precharge/evaluate sequencer driving BUSES dynamic register buses
module sm83_reg_bus_pch_seq
    import sm83_reg_bus_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               BUSES        = 3,
    parameter int               PCH_CYCLES   = 1,
    parameter logic [WIDTH-1:0] ZERO_MASK    = 8'h0F,
    parameter int               DECAY_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sm83_reg_bus_pch_seq_if.slave rb
);

    localparam int PW = (PCH_CYCLES > 1) ? $clog2(PCH_CYCLES) : 1;
    localparam int DW = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PCH_LAST = PW'(PCH_CYCLES - 1);
    localparam logic [DW-1:0] DMAX     = DW'(DECAY_CYCLES);

    reg_bus_state_t state, state_nx;
    logic [PW-1:0]  pch_cnt, pch_cnt_nx;
    logic [DW-1:0]  dcnt, dcnt_nx;
    logic           stale, stale_nx;
    logic           pch_stb, eval_stb, dis_stb, decay_stb;

    logic [BUSES*WIDTH-1:0] bus_q_w;
    logic [BUSES*WIDTH-1:0] sample_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pch_cnt <= '0;
            dcnt    <= '0;
            stale   <= 1'b1;
        end else begin
            state   <= state_nx;
            pch_cnt <= pch_cnt_nx;
            dcnt    <= dcnt_nx;
            stale   <= stale_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pch_cnt_nx = pch_cnt;
        dcnt_nx    = dcnt;
        stale_nx   = stale;
        pch_stb    = 1'b0;
        eval_stb   = 1'b0;
        dis_stb    = 1'b0;
        decay_stb  = 1'b0;
        case (state)
            IDLE, DONE: begin
                dis_stb = 1'b1;
                // Saturating leakage timer; fires once on the edge it reaches the limit
                if (DECAY_CYCLES != 0 && dcnt != DMAX) begin
                    dcnt_nx = dcnt + 1'b1;
                    if (dcnt_nx == DMAX) begin
                        decay_stb = 1'b1;
                        stale_nx  = 1'b1;
                    end
                end
                if (rb.start) begin
                    state_nx   = PCH;
                    pch_cnt_nx = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            PCH: begin
                pch_stb  = 1'b1;
                stale_nx = 1'b0;
                dcnt_nx  = '0;
                if (pch_cnt == PCH_LAST) begin
                    state_nx = EVAL;
                end else begin
                    pch_cnt_nx = pch_cnt + 1'b1;
                end
            end
            EVAL: begin
                eval_stb = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    for (genvar b = 0; b < BUSES; b++) begin : g_lane
        sm83_reg_bus_lane #(
            .WIDTH     (WIDTH),
            .ZERO_MASK (ZERO_MASK)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .pch_stb   (pch_stb),
            .eval_stb  (eval_stb),
            .dis_stb   (dis_stb),
            .decay_stb (decay_stb),
            .pd        (rb.pd[lane_lo(b, WIDTH) +: WIDTH]),
            .zero_en   (rb.zero_en[b]),
            .bus_q     (bus_q_w[lane_lo(b, WIDTH) +: WIDTH]),
            .sample    (sample_w[lane_lo(b, WIDTH) +: WIDTH])
        );
    end

    assign rb.bus_q        = bus_q_w;
    assign rb.bus_q_n      = ~bus_q_w;
    assign rb.sample       = sample_w;
    assign rb.sample_valid = (state == DONE);
    assign rb.ready        = (state == IDLE) || (state == DONE);
    assign rb.stale        = stale;

endmodule

// File: tb/tb_sm83_reg_bus_pch_seq.sv
// tb/tb_sm83_reg_bus_pch_seq.sv - directed self-checking bench for the register bus sequencer
module tb_sm83_reg_bus_pch_seq;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    sm83_reg_bus_pch_seq_if #(.WIDTH(8), .BUSES(3)) rb0 ();
    sm83_reg_bus_pch_seq_if #(.WIDTH(8), .BUSES(3)) rb1 ();

    sm83_reg_bus_pch_seq #(
        .WIDTH(8), .BUSES(3), .PCH_CYCLES(1), .ZERO_MASK(8'h0F), .DECAY_CYCLES(4)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .rb    (rb0.slave)
    );

    sm83_reg_bus_pch_seq #(
        .WIDTH(8), .BUSES(3), .PCH_CYCLES(2), .ZERO_MASK(8'h0F), .DECAY_CYCLES(4)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .rb    (rb1.slave)
    );

    typedef struct {
        logic [23:0] pd;
        logic [2:0]  ze;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{pd: 24'h000000, ze: 3'b000, exp: 24'hFFFFFF};
        vecs[1] = '{pd: 24'h00A500, ze: 3'b010, exp: 24'hFF50FF};
        vecs[2] = '{pd: 24'h800001, ze: 3'b101, exp: 24'h70FFF0};
        vecs[3] = '{pd: 24'h000000, ze: 3'b111, exp: 24'hF0F0F0};
        vecs[4] = '{pd: 24'hFFFFFF, ze: 3'b000, exp: 24'h000000};
        vecs[5] = '{pd: 24'h00F000, ze: 3'b010, exp: 24'hFF00FF};

        reset = 1'b1;
        rb0.start = 1'b0; rb0.pd = '0; rb0.zero_en = '0;
        rb1.start = 1'b0; rb1.pd = '0; rb1.zero_en = '0;
        step();
        step();
        reset = 1'b0;

        check("rst_ready",   64'(rb0.ready), 64'd1);
        check("rst_bus_q",   64'(rb0.bus_q), 64'h0);
        check("rst_bus_q_n", 64'(rb0.bus_q_n), 64'hFFFFFF);
        check("rst_sample",  64'(rb0.sample), 64'h0);
        check("rst_valid",   64'(rb0.sample_valid), 64'd0);
        check("rst_stale",   64'(rb0.stale), 64'd1);

        for (int i = 0; i < 6; i++) begin
            rb0.pd = vecs[i].pd;
            rb0.zero_en = vecs[i].ze;
            rb0.start = 1'b1;
            step();
            rb0.start = 1'b0;
            check($sformatf("v%0d_ready_pch", i), 64'(rb0.ready), 64'd0);
            step();
            check($sformatf("v%0d_stale_after_pch", i), 64'(rb0.stale), 64'd0);
            step();
            check($sformatf("v%0d_valid", i), 64'(rb0.sample_valid), 64'd1);
            check($sformatf("v%0d_sample", i), 64'(rb0.sample), 64'(vecs[i].exp));
            step();
            check($sformatf("v%0d_valid_drop", i), 64'(rb0.sample_valid), 64'd0);
        end

        // Leakage: bus held high for 3 edges after evaluate, gone on the 4th
        rb0.pd = '0; rb0.zero_en = '0;
        rb0.start = 1'b1;
        step();
        rb0.start = 1'b0;
        step();
        step();
        check("dec_bus_eval", 64'(rb0.bus_q), 64'hFFFFFF);
        step();
        step();
        step();
        check("dec_bus_e3", 64'(rb0.bus_q), 64'hFFFFFF);
        check("dec_stale_e3", 64'(rb0.stale), 64'd0);
        step();
        check("dec_bus_e4", 64'(rb0.bus_q), 64'h0);
        check("dec_stale_e4", 64'(rb0.stale), 64'd1);
        rb0.start = 1'b1;
        step();
        rb0.start = 1'b0;
        check("dec_stale_start", 64'(rb0.stale), 64'd1);
        step();
        check("dec_stale_pch", 64'(rb0.stale), 64'd0);
        check("dec_bus_pch", 64'(rb0.bus_q), 64'hFFFFFF);
        step();
        step();

        // Idle discharge pulse on bit 3 must not recover until the next precharge
        rb0.start = 1'b1;
        step();
        rb0.start = 1'b0;
        step();
        step();
        rb0.pd = 24'h000008;
        step();
        rb0.pd = '0;
        check("pulse_bus_d", 64'(rb0.bus_q), 64'hFFFFF7);
        step();
        check("pulse_bus_i1", 64'(rb0.bus_q), 64'hFFFFF7);
        check("pulse_bus_n", 64'(rb0.bus_q_n), 64'h000008);
        step();
        check("pulse_bus_i2", 64'(rb0.bus_q), 64'hFFFFF7);
        rb0.start = 1'b1;
        step();
        rb0.start = 1'b0;
        step();
        check("pulse_bus_pch", 64'(rb0.bus_q), 64'hFFFFFF);
        step();
        step();

        // Back-to-back with a two-cycle precharge: DONE every fourth cycle
        rb1.start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("b2b_valid_%0d", i), 64'(rb1.sample_valid), 64'((i % 4) == 0));
            check($sformatf("b2b_ready_%0d", i), 64'(rb1.ready), 64'((i % 4) == 0));
        end
        rb1.start = 1'b0;
        check("b2b_sample", 64'(rb1.sample), 64'hFFFFFF);
        step();

        // Reset while in EVAL aborts the transaction
        rb0.start = 1'b1;
        step();
        rb0.start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", 64'(rb0.ready), 64'd1);
        check("abort_bus_q", 64'(rb0.bus_q), 64'h0);
        check("abort_valid", 64'(rb0.sample_valid), 64'd0);
        check("abort_stale", 64'(rb0.stale), 64'd1);
        check("abort_sample", 64'(rb0.sample), 64'h0);
        step();
        check("abort_valid_next", 64'(rb0.sample_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sm83_reg_bus_pch_seq.md
# sm83_reg_bus_pch_seq

Parametrised, clocked precharge/evaluate sequencer for SM83 dynamic register buses. It generalises the single-lane precharge cell to BUSES buses of WIDTH bits each, with a per-bit zero-force mask, a configurable precharge length, and a sample register with a valid pulse. It also models leakage: a bus left un-precharged for too long decays to zero and is flagged stale. It sits between the register-file read ports and the bus consumers (ALU/IDU operand latches).

## Interface
- WIDTH, 8: bits per bus.
- BUSES, 3: number of independent buses sharing one sequencer.
- PCH_CYCLES, 1: precharge phase length in clocks, ≥1.
- ZERO_MASK, 8'h0F: WIDTH-bit mask of bits that `zero_en` can force low.
- DECAY_CYCLES, 4: idle clocks after evaluate before the bus decays; 0 disables decay.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; accepted only when `ready`=1.
- ready  out  1  high in IDLE and DONE.
- pd  in  BUSES*WIDTH  pull-down drivers, 1 = discharge that bit; bus b uses bits [b*WIDTH +: WIDTH].
- zero_en  in  BUSES  force ZERO_MASK bits of bus b low during EVAL.
- bus_q  out  BUSES*WIDTH  current dynamic bus value.
- bus_q_n  out  BUSES*WIDTH  combinational ~bus_q.
- sample  out  BUSES*WIDTH  value captured at EVAL.
- sample_valid  out  1  one-cycle pulse when `sample` is updated.
- stale  out  1  bus not precharged since reset or decay.

## Operation
- FSM states: IDLE, PCH, EVAL, DONE.
- IDLE:
  - start=1 → PCH.
  - Otherwise stay. bus_q <= bus_q & ~pd (monotonic discharge only).
- PCH:
  - bus_q <= all ones; stale <= 0; decay counter <= 0.
  - Stays for PCH_CYCLES edges, then → EVAL.
  - start and pd are ignored.
- EVAL (one edge):
  - Per bus b: v = bus_q[b] & ~pd[b] & ~(zero_en[b] ? ZERO_MASK : 0).
  - bus_q <= v; sample <= v; → DONE.
- DONE (one cycle):
  - sample_valid=1.
  - start=1 → PCH (back-to-back); otherwise → IDLE.
  - Discharge continues as in IDLE.
- Decay:
  - A saturating counter increments on each IDLE/DONE edge, width $clog2(DECAY_CYCLES+1).
  - On the edge where it reaches DECAY_CYCLES: bus_q <= 0, stale <= 1.
  - The counter holds until the next PCH.
- Reset values: state IDLE, bus_q 0, sample 0, sample_valid 0, stale 1, counter 0, ready 1.
- Reset mid-transaction aborts immediately. No sample_valid is produced for the aborted transaction.
- A bit can never rise outside PCH. This is an assertion.
- zero_en on bits outside ZERO_MASK has no effect.

## Timing
- Edge k samples start=1 in IDLE or DONE.
- Edges k+1 .. k+PCH_CYCLES are the precharge edges. bus_q is all ones after edge k+1.
- Edge k+PCH_CYCLES+1 is the evaluate edge.
- sample_valid is high in the cycle after the evaluate edge.
- Start-to-valid latency is PCH_CYCLES+2 edges.
- Back-to-back throughput is one transaction per PCH_CYCLES+2 clocks.
- pd and zero_en must be stable in the cycle before the evaluate edge. They are sampled only at that edge for `sample`.
- bus_q_n has zero clock latency relative to bus_q.
- Decay counts edges starting after the evaluate edge; DONE counts as the first. With DECAY_CYCLES=4 and no new start, bus_q=0 and stale=1 after evaluate edge + 4.

## Structure
- Package `sm83_reg_bus_pkg`:
  - `reg_bus_state_t` enum (IDLE, PCH, EVAL, DONE).
  - Helper function for the lane slice index.
- Sub-module `sm83_reg_bus_lane` (WIDTH, ZERO_MASK):
  - One per bus, generated BUSES times.
  - Holds that bus's bus_q/sample registers and discharge/zero logic.
  - Controlled by phase strobes from the top-level FSM.
- The top level owns the FSM, the decay counter, stale, ready and sample_valid.

## Test plan
- Reset, then start=1, pd=0, zero_en=0, with defaults → sample_valid at edge 3 after start; sample = 24'hFFFFFF; stale=0.
- Bus 1 pd=8'hA5, zero_en=3'b010 at EVAL → sample bus1 = 8'h50 (~8'hA5 & ~8'h0F); buses 0 and 2 = 8'hFF.
- start held high continuously, PCH_CYCLES=2 → sample_valid every 4 clocks; ready=1 only in IDLE/DONE cycles.
- After a transaction, pd=0 and no start for 4 edges → bus_q=0 and stale=1 on the 4th edge; the next start clears stale after its first PCH edge.
- reset asserted during EVAL → next cycle state IDLE, bus_q=0, sample_valid stays 0, stale=1.
- In IDLE, pulse pd bit 3 and then release it → bit 3 stays 0 until the next PCH; the no-rise assertion never fires.
